parity_block_engine: RTL and testbench
======================================

Name: parity_block_engine

Overview:
- Sequential, parametrised successor to the combinational byte-parity datapath.
- Accepts a burst of N word pairs (A, B) over a valid/ready stream after a start pulse.
- Per accepted beat, computes bitwise parity A^B and accumulates column parity across the burst.
- Produces a reduced word parity (even/odd selectable) and a one-cycle done pulse. Sits between the stimulus sequencer and the scoreboard in the lab datapath.

Parameters:
- DATA_WIDTH, 8, width of byte_a/byte_b and all parity vectors.
- MAX_WORDS, 16, maximum burst length; num_words above this is clamped.
- CNT_W, $clog2(MAX_WORDS+1), width of the counters. Localparam; not overridable.

Ports:
- clk  input  1  single clock; all state is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  burst request; sampled only in IDLE.
- num_words  input  CNT_W  burst length; latched on accepted start.
- odd_mode  input  1  latched on start; 1 = odd parity, 0 = even parity for word_parity.
- in_valid  input  1  beat presented.
- in_ready  output  1  engine accepts a beat this cycle.
- byte_a  input  DATA_WIDTH  operand A.
- byte_b  input  DATA_WIDTH  operand B.
- byte_parity  output  DATA_WIDTH  registered A^B of the last accepted beat.
- col_parity  output  DATA_WIDTH  running XOR of all byte_parity values in the current burst.
- word_parity  output  1  ^col_parity XOR odd_mode_q; valid when done=1.
- beat_count  output  CNT_W  beats accepted in the current burst.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values (async, rst_n=0):
  - state=IDLE.
  - All of these are 0: in_ready, byte_parity, col_parity, word_parity, beat_count, busy, done, and the latched len and odd_mode_q.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=0.
  - On start=1: latch len=min(num_words,MAX_WORDS) and odd_mode_q. Clear col_parity, byte_parity and beat_count.
  - If len==0, go to DONE. Otherwise go to RUN.
- RUN:
  - in_ready=1 combinationally from state.
  - A beat is accepted when in_valid&&in_ready. On each accepted beat:
    - byte_parity<=a^b
    - col_parity<=col_parity^a^b
    - beat_count<=beat_count+1
  - On the beat where beat_count==len-1, go to DONE in the same edge.
  - No beat is accepted when in_valid=0. State holds with no timeout.
  - start is ignored in RUN.
- DONE:
  - done=1 for exactly one cycle and in_ready=0.
  - word_parity=(^col_parity)^odd_mode_q, registered on entry so it is valid while done=1.
  - Always returns to IDLE next cycle. start is ignored in DONE.
- Latency:
  - Burst of N beats with in_valid held high: done asserts N+1 cycles after the start edge.
  - len==0: done asserts 1 cycle after the start edge.
- Outputs byte_parity, col_parity, word_parity and beat_count hold their values in IDLE until the next accepted start.
- Reset mid-burst: immediate return to reset values. A partial burst is discarded and no done is produced.
- beat_count never exceeds len and does not wrap.

Optional Feature:
- Macro: PARITY_BLOCK_CHECK_EN.
- Defined:
  - Adds input exp_parity [DATA_WIDTH-1:0], latched on accepted start.
  - Adds output parity_err, 1 bit. It is set in DONE if col_parity!=exp_parity_q and cleared on the next accepted start or on reset.
- Undefined: neither port exists; behaviour is otherwise identical.

Decomposition:
- Package parity_block_pkg:
  - state enum type pb_state_t {PB_IDLE, PB_RUN, PB_DONE}, 2-bit encoding.
  - Default DATA_WIDTH and MAX_WORDS constants.
- One sub-module, parity_lane: a 1-bit slice holding the byte_parity and col_parity flops, with load/clear/accumulate controls. Instantiated DATA_WIDTH times via generate.
- The FSM and counters live in the top module.

Test Plan:
- Reset mid-burst → all outputs 0. Then a new burst N=1, a=0x0F, b=0x0F gives col_parity=0x00, word_parity=0, done pulses.
- N=3, even mode, beats (0xFF,0x00), (0x0F,0x00), (0x01,0x00) with in_valid constant:
  - byte_parity tracks 0xFF, 0x0F, 0x01.
  - col_parity=0xF1, word_parity=1, done exactly at cycle 4.
- Same burst with odd_mode=1 → word_parity=0. Insert in_valid gaps of 2 cycles → identical col_parity; done delayed by the number of gap cycles; beat_count=3.
- num_words=0 → done one cycle after start, col_parity=0x00, in_ready never high. num_words=31 with MAX_WORDS=16 → exactly 16 beats accepted.
- start pulsed during RUN and DONE → ignored, len unchanged. Back-to-back start asserted in the same cycle as the return to IDLE → new burst begins cleanly.
- With PARITY_BLOCK_CHECK_EN:
  - exp_parity=0xF1 on the 3-beat burst → parity_err=0.
  - exp_parity=0xF0 → parity_err=1 at done; cleared on next start.

Source files
------------

// File: rtl/parity_block_engine_pkg.sv
// Shared types and default sizing for the parity block engine.
package parity_block_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_WORDS  = 16;

  typedef enum logic [1:0] {
    PB_IDLE = 2'd0,
    PB_RUN  = 2'd1,
    PB_DONE = 2'd2
  } pb_state_t;

endpackage

// File: rtl/parity_block_engine_lane.sv
// One bit of the parity datapath: last-beat parity and running column parity.
// clear has priority over load so a start in the same cycle always wins.
module parity_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic load,
  input  logic a,
  input  logic b,
  output logic byte_par,
  output logic col_par,
  output logic col_next
);

  // Value the column flop will hold after this edge (used for word parity on DONE entry).
  always_comb begin
    col_next = col_par;
    if (clear) begin
      col_next = 1'b0;
    end else if (load) begin
      col_next = col_par ^ a ^ b;
    end else begin
      col_next = col_par;
    end
  end

  // Lane flops: clear on start, update on accepted beat, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_par <= 1'b0;
      col_par  <= 1'b0;
    end else if (clear) begin
      byte_par <= 1'b0;
      col_par  <= 1'b0;
    end else if (load) begin
      byte_par <= a ^ b;
      col_par  <= col_next;
    end else begin
      byte_par <= byte_par;
      col_par  <= col_par;
    end
  end

endmodule

// File: rtl/parity_block_engine.sv
// Burst parity engine: accepts len word pairs over valid/ready, accumulates
// column parity and reports a reduced word parity with a one-cycle done.
// Optional self-check against an expected column parity: PARITY_BLOCK_CHECK_EN.
module parity_block_engine
  import parity_block_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_WORDS  = DEF_MAX_WORDS,
  localparam int CNT_W      = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [CNT_W-1:0]      num_words,
  input  logic                  odd_mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] byte_a,
  input  logic [DATA_WIDTH-1:0] byte_b,
  output logic [DATA_WIDTH-1:0] byte_parity,
  output logic [DATA_WIDTH-1:0] col_parity,
  output logic                  word_parity,
  output logic [CNT_W-1:0]      beat_count,
  output logic                  busy,
`ifdef PARITY_BLOCK_CHECK_EN
  input  logic [DATA_WIDTH-1:0] exp_parity,
  output logic                  parity_err,
`endif
  output logic                  done
);

  localparam logic [CNT_W-1:0] MAX_LEN  = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  // Reduced parity of a vector, inverted when odd parity is requested.
  function automatic logic reduce_parity(input logic [DATA_WIDTH-1:0] v, input logic odd);
    return (^v) ^ odd;
  endfunction

  pb_state_t             state;
  pb_state_t             next_state;
  logic [CNT_W-1:0]      len;
  logic [CNT_W-1:0]      len_in;
  logic                  odd_mode_q;
  logic                  odd_sel;
  logic                  start_acc;
  logic                  accept;
  logic                  last_beat;
  logic [DATA_WIDTH-1:0] col_next;

  assign in_ready  = (state == PB_RUN);
  assign accept    = in_valid && in_ready;
  assign start_acc = (state == PB_IDLE) && start;

  // Clamp the requested length and pick the parity sense valid for this edge.
  always_comb begin
    len_in    = (num_words > MAX_LEN) ? MAX_LEN : num_words;
    odd_sel   = (state == PB_IDLE) ? odd_mode : odd_mode_q;
    last_beat = accept && (beat_count == (len - CNT_ONE));
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      PB_IDLE: begin
        if (start_acc) begin
          next_state = (len_in == CNT_ZERO) ? PB_DONE : PB_RUN;
        end else begin
          next_state = PB_IDLE;
        end
      end
      PB_RUN: begin
        if (last_beat) begin
          next_state = PB_DONE;
        end else begin
          next_state = PB_RUN;
        end
      end
      PB_DONE: next_state = PB_IDLE;
      default: next_state = PB_IDLE;
    endcase
  end

  // State, burst configuration, beat counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PB_IDLE;
      len         <= CNT_ZERO;
      odd_mode_q  <= 1'b0;
      beat_count  <= CNT_ZERO;
      word_parity <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != PB_IDLE);
      done  <= (next_state == PB_DONE);
      if (start_acc) begin
        len        <= len_in;
        odd_mode_q <= odd_mode;
        beat_count <= CNT_ZERO;
      end else if (accept) begin
        beat_count <= beat_count + CNT_ONE;
      end else begin
        beat_count <= beat_count;
      end
      if (next_state == PB_DONE) begin
        word_parity <= reduce_parity(col_next, odd_sel);
      end else begin
        word_parity <= word_parity;
      end
    end
  end

  // Bit-sliced parity datapath.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_lane
    parity_lane u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (start_acc),
      .load     (accept),
      .a        (byte_a[i]),
      .b        (byte_b[i]),
      .byte_par (byte_parity[i]),
      .col_par  (col_parity[i]),
      .col_next (col_next[i])
    );
  end

`ifdef PARITY_BLOCK_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_parity_q;
  logic [DATA_WIDTH-1:0] exp_sel;

  // Expected parity in force for this edge (fresh value on a zero-length start).
  always_comb begin
    exp_sel = (state == PB_IDLE) ? exp_parity : exp_parity_q;
  end

  // Latch expectation on start; flag a mismatch on DONE entry, clear on next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_parity_q <= {DATA_WIDTH{1'b0}};
      parity_err   <= 1'b0;
    end else begin
      if (start_acc) begin
        exp_parity_q <= exp_parity;
      end else begin
        exp_parity_q <= exp_parity_q;
      end
      if (next_state == PB_DONE) begin
        parity_err <= (col_next != exp_sel);
      end else if (start_acc) begin
        parity_err <= 1'b0;
      end else begin
        parity_err <= parity_err;
      end
    end
  end
`endif

endmodule

// File: tb/tb_parity_block_engine.sv
// Directed self-checking bench for parity_block_engine (default MAX_WORDS=16).
module tb_parity_block_engine;

  localparam int DW = 8;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] num_words = '0;
  logic          odd_mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] byte_a = '0;
  logic [DW-1:0] byte_b = '0;
  logic [DW-1:0] byte_parity;
  logic [DW-1:0] col_parity;
  logic          word_parity;
  logic [CW-1:0] beat_count;
  logic          busy;
  logic          done;
`ifdef PARITY_BLOCK_CHECK_EN
  logic [DW-1:0] exp_parity = '0;
  logic          parity_err;
`endif

  int checks = 0;
  int passes = 0;
  logic [DW-1:0] va [0:31];
  logic [DW-1:0] vb [0:31];

  always #5 clk = ~clk;

  parity_block_engine dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .odd_mode    (odd_mode),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .byte_a      (byte_a),
    .byte_b      (byte_b),
    .byte_parity (byte_parity),
    .col_parity  (col_parity),
    .word_parity (word_parity),
    .beat_count  (beat_count),
    .busy        (busy),
`ifdef PARITY_BLOCK_CHECK_EN
    .exp_parity  (exp_parity),
    .parity_err  (parity_err),
`endif
    .done        (done)
  );

  // Start a burst and feed va/vb beats; returns on the done cycle (or after a bound).
  // done_cyc counts negedges after the start edge until done is seen (-1 = timeout).
  task automatic run_burst(input int n, input logic odd, input int gap, input bit start_in_run,
                           output int done_cyc, output int nbeats, output bit saw_ready,
                           output int bp_bad);
    logic [DW-1:0] exp_bp;
    int idx, gapcnt, cyc;
    bit pending;
    exp_bp = '0; idx = 0; gapcnt = 0; cyc = 0; pending = 0;
    done_cyc = -1; nbeats = 0; saw_ready = 0; bp_bad = 0;
    @(negedge clk);
    start = 1'b1; num_words = n[CW-1:0]; odd_mode = odd; in_valid = 1'b0;
    @(posedge clk);
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (pending) begin
        if (byte_parity !== exp_bp) bp_bad++;
        pending = 0;
      end
      if (start_in_run && cyc == 1) begin
        start = 1'b1; num_words = 5'd9;
      end
      if (done) begin
        done_cyc = cyc; in_valid = 1'b0;
        break;
      end
      if (in_ready) saw_ready = 1;
      if (in_ready && gapcnt == 0 && idx < 32) begin
        in_valid = 1'b1; byte_a = va[idx]; byte_b = vb[idx];
      end else begin
        in_valid = 1'b0;
        if (in_ready && gapcnt > 0) gapcnt--;
      end
      if (in_valid && in_ready) begin
        exp_bp = byte_a ^ byte_b; idx++; nbeats++; gapcnt = gap; pending = 1;
      end
    end
  endtask

  task automatic test_reset();
    int dc, nb, bb; bit sr;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, byte_parity, col_parity, word_parity, beat_count, busy, done} !== '0)
      $display("FAIL reset_state: got %h expected 0", {in_ready, byte_parity, col_parity, word_parity, beat_count, busy, done});
    else passes++;
    rst_n = 1'b1;
    // start a 5-beat burst and kill it after two beats
    @(negedge clk);
    start = 1'b1; num_words = 5'd5; odd_mode = 1'b1; in_valid = 1'b1; byte_a = 8'h5A; byte_b = 8'h00;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, byte_parity, col_parity, word_parity, beat_count, busy, done} !== '0)
      $display("FAIL reset_midburst: got %h expected 0", {in_ready, byte_parity, col_parity, word_parity, beat_count, busy, done});
    else passes++;
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    va[0] = 8'h0F; vb[0] = 8'h0F;
    run_burst(1, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (dc !== 2) $display("FAIL post_reset_done_cycle: got %0d expected 2", dc); else passes++;
    checks++;
    if ({col_parity, word_parity, byte_parity} !== {8'h00, 1'b0, 8'h00})
      $display("FAIL post_reset_parity: got col=%h word=%b byte=%h expected col=00 word=0 byte=00", col_parity, word_parity, byte_parity);
    else passes++;
  endtask

  task automatic test_even_burst();
    int dc, nb, bb; bit sr;
    va[0] = 8'hFF; va[1] = 8'h0F; va[2] = 8'h01;
    vb[0] = 8'h00; vb[1] = 8'h00; vb[2] = 8'h00;
    run_burst(3, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (dc !== 4) $display("FAIL even_done_cycle: got %0d expected 4", dc); else passes++;
    checks++;
    if (bb !== 0) $display("FAIL even_byte_parity_track: got %0d bad beats expected 0", bb); else passes++;
    checks++;
    if (col_parity !== 8'hF1) $display("FAIL even_col_parity: got %h expected f1", col_parity); else passes++;
    checks++;
    if (word_parity !== 1'b1) $display("FAIL even_word_parity: got %b expected 1", word_parity); else passes++;
    checks++;
    if (beat_count !== 5'd3) $display("FAIL even_beat_count: got %0d expected 3", beat_count); else passes++;
    @(negedge clk);
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL done_one_cycle: got done=%b busy=%b expected 0 0", done, busy); else passes++;
    checks++;
    if (col_parity !== 8'hF1) $display("FAIL idle_hold_col: got %h expected f1", col_parity); else passes++;
  endtask

  task automatic test_odd_gaps();
    int dc, nb, bb; bit sr;
    run_burst(3, 1'b1, 2, 0, dc, nb, sr, bb);
    checks++;
    if (dc !== 8) $display("FAIL gap_done_cycle: got %0d expected 8", dc); else passes++;
    checks++;
    if (col_parity !== 8'hF1) $display("FAIL gap_col_parity: got %h expected f1", col_parity); else passes++;
    checks++;
    if (word_parity !== 1'b0) $display("FAIL odd_word_parity: got %b expected 0", word_parity); else passes++;
    checks++;
    if (beat_count !== 5'd3) $display("FAIL gap_beat_count: got %0d expected 3", beat_count); else passes++;
  endtask

  task automatic test_zero_len();
    int dc, nb, bb; bit sr;
    run_burst(0, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (dc !== 1) $display("FAIL zero_done_cycle: got %0d expected 1", dc); else passes++;
    checks++;
    if ({col_parity, word_parity, beat_count} !== {8'h00, 1'b0, 5'd0})
      $display("FAIL zero_outputs: got col=%h word=%b cnt=%0d expected 00 0 0", col_parity, word_parity, beat_count);
    else passes++;
    checks++;
    if (sr !== 1'b0) $display("FAIL zero_in_ready: got %b expected 0", sr); else passes++;
  endtask

  task automatic test_clamp();
    int dc, nb, bb; bit sr;
    for (int i = 0; i < 32; i++) begin
      va[i] = 8'(i); vb[i] = 8'h00;
    end
    vb[0] = 8'h3C;
    run_burst(31, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (nb !== 16) $display("FAIL clamp_beats: got %0d expected 16", nb); else passes++;
    checks++;
    if (beat_count !== 5'd16) $display("FAIL clamp_beat_count: got %0d expected 16", beat_count); else passes++;
    checks++;
    if (dc !== 17) $display("FAIL clamp_done_cycle: got %0d expected 17", dc); else passes++;
    checks++;
    if ({col_parity, word_parity} !== {8'h3C, 1'b0})
      $display("FAIL clamp_parity: got col=%h word=%b expected 3c 0", col_parity, word_parity);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int dc, nb, bb; bit sr;
    va[0] = 8'h12; va[1] = 8'h34; vb[0] = 8'h00; vb[1] = 8'h00;
    run_burst(2, 1'b0, 0, 1, dc, nb, sr, bb);
    checks++;
    if (dc !== 3 || nb !== 2) $display("FAIL start_in_run: got done_cyc=%0d beats=%0d expected 3 2", dc, nb); else passes++;
    checks++;
    if ({col_parity, word_parity, beat_count} !== {8'h26, 1'b1, 5'd2})
      $display("FAIL start_in_run_result: got col=%h word=%b cnt=%0d expected 26 1 2", col_parity, word_parity, beat_count);
    else passes++;
    // currently in the DONE cycle: a start here must be ignored
    start = 1'b1; num_words = 5'd4;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, done} !== 3'b000) $display("FAIL start_in_done: got busy=%b ready=%b done=%b expected 0 0 0", busy, in_ready, done); else passes++;
  endtask

  task automatic test_back_to_back();
    int dc, nb, bb; bit sr;
    va[0] = 8'hAA; vb[0] = 8'h55;
    run_burst(1, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if ({col_parity, word_parity} !== {8'hFF, 1'b0}) $display("FAIL b2b_first: got col=%h word=%b expected ff 0", col_parity, word_parity); else passes++;
    va[0] = 8'h01; va[1] = 8'h02; vb[0] = 8'h00; vb[1] = 8'h00;
    run_burst(2, 1'b1, 0, 0, dc, nb, sr, bb);
    checks++;
    if (dc !== 3) $display("FAIL b2b_done_cycle: got %0d expected 3", dc); else passes++;
    checks++;
    if ({col_parity, word_parity, beat_count} !== {8'h03, 1'b1, 5'd2})
      $display("FAIL b2b_second: got col=%h word=%b cnt=%0d expected 03 1 2", col_parity, word_parity, beat_count);
    else passes++;
  endtask

`ifdef PARITY_BLOCK_CHECK_EN
  task automatic test_check_en();
    int dc, nb, bb; bit sr;
    va[0] = 8'hFF; va[1] = 8'h0F; va[2] = 8'h01;
    vb[0] = 8'h00; vb[1] = 8'h00; vb[2] = 8'h00;
    exp_parity = 8'hF1;
    run_burst(3, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (parity_err !== 1'b0) $display("FAIL check_match: got %b expected 0", parity_err); else passes++;
    exp_parity = 8'hF0;
    run_burst(3, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (parity_err !== 1'b1) $display("FAIL check_mismatch: got %b expected 1", parity_err); else passes++;
    exp_parity = 8'h00;
    run_burst(0, 1'b0, 0, 0, dc, nb, sr, bb);
    checks++;
    if (parity_err !== 1'b0) $display("FAIL check_cleared: got %b expected 0", parity_err); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_even_burst();
    test_odd_gaps();
    test_zero_len();
    test_clamp();
    test_start_ignored();
    test_back_to_back();
`ifdef PARITY_BLOCK_CHECK_EN
    test_check_en();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
